// File: rtl/fiber_arb_pkg.sv
// Shared types and constants for the fiber_access tile memory arbiter.
package fiber_arb_pkg;

    localparam int FIBER_MEM_ADDR_W = 9;
    localparam int FIBER_MEM_DATA_W = 64;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic inc);
        return (inc && (value != 16'hFFFF)) ? value + 16'd1 : value;
    endfunction

endpackage

// File: rtl/fiber_rsp_fifo.sv
// First-word fall-through response FIFO; an empty FIFO presents the incoming push word directly.
module fiber_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;
    logic             full;
    logic             pop_ok;
    logic             take;
    logic             push_ok;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        valid    = !empty || push;
        pop_data = empty ? push_data : mem_q[rd_ptr_q];
        pop_ok   = pop && valid && clk_en && !flush;
        take     = pop_ok && !empty;
        // A word consumed straight through the bypass is never stored.
        push_ok  = push && clk_en && !flush && !(empty && pop_ok) && (!full || take);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (take) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, take})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

    // Read credit upstream makes this unreachable.
    always @(posedge clk) begin
        if (rst_n && clk_en && !flush) begin
            assert (!(push && full && !take));
        end
    end

endmodule

// File: rtl/fiber_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between write and read requesters, with credit-metered reads.
// Optional grant/conflict statistics counters are enabled by defining FIBER_ARB_STATS_EN.
module fiber_mem_arbiter
    import fiber_arb_pkg::*;
#(
    parameter int ADDR_W    = FIBER_MEM_ADDR_W,
    parameter int DATA_W    = FIBER_MEM_DATA_W,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] addr_to_mem,
    output logic [DATA_W-1:0] data_to_mem,
    output logic              wen_to_mem,
    output logic              ren_to_mem,
    input  logic [DATA_W-1:0] data_from_mem
`ifdef FIBER_ARB_STATS_EN
    ,
    output logic [15:0]       wr_grant_cnt,
    output logic [15:0]       rd_grant_cnt,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    grant_e            grant;
    grant_e            last_grant_q, last_grant_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              rd_ok;
    logic              rd_elig;
    logic              active;

    always_comb begin
        occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
        rd_ok     = occupancy < (CNT_W + 1)'(RSP_DEPTH);
        rd_elig   = rd_valid && rd_ok;
        active    = rst_n && clk_en && !flush;

        grant = GNT_NONE;
        if (active) begin
            if (wr_valid && rd_elig) begin
                grant = (last_grant_q == GNT_WR) ? GNT_RD : GNT_WR;
            end else if (wr_valid) begin
                grant = GNT_WR;
            end else if (rd_elig) begin
                grant = GNT_RD;
            end
        end

        wr_ready    = (grant == GNT_WR);
        rd_ready    = (grant == GNT_RD);
        wen_to_mem  = wr_ready;
        ren_to_mem  = rd_ready;
        addr_to_mem = addr_q;
        data_to_mem = data_q;
        if (grant == GNT_WR) begin
            addr_to_mem = wr_addr;
            data_to_mem = wr_data;
        end else if (grant == GNT_RD) begin
            addr_to_mem = rd_addr;
        end
        if (flush) begin
            addr_to_mem = '0;
            data_to_mem = '0;
        end

        inflight_d   = inflight_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        data_d       = data_q;
        if (flush) begin
            inflight_d   = 1'b0;
            last_grant_d = GNT_WR;
            addr_d       = '0;
            data_d       = '0;
        end else if (clk_en) begin
            inflight_d = (grant == GNT_RD);
            if (grant != GNT_NONE) begin
                last_grant_d = grant;
            end
            addr_d = addr_to_mem;
            data_d = data_to_mem;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q   <= 1'b0;
            last_grant_q <= GNT_WR;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            inflight_q   <= inflight_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
        end
    end

    // The SRAM returns data the cycle after the read grant, exactly when inflight is set.
    fiber_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .flush     (flush),
        .push      (inflight_q),
        .push_data (data_from_mem),
        .pop       (rsp_ready),
        .pop_data  (rsp_data),
        .valid     (rsp_valid),
        .count     (fifo_count)
    );

`ifdef FIBER_ARB_STATS_EN
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] conf_cnt_q, conf_cnt_d;

    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        conf_cnt_d = conf_cnt_q;
        if (flush) begin
            wr_cnt_d   = '0;
            rd_cnt_d   = '0;
            conf_cnt_d = '0;
        end else if (clk_en) begin
            wr_cnt_d   = sat_inc16(wr_cnt_q, grant == GNT_WR);
            rd_cnt_d   = sat_inc16(rd_cnt_q, grant == GNT_RD);
            conf_cnt_d = sat_inc16(conf_cnt_q, wr_valid && rd_valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            conf_cnt_q <= '0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            conf_cnt_q <= conf_cnt_d;
        end
    end

    assign wr_grant_cnt = wr_cnt_q;
    assign rd_grant_cnt = rd_cnt_q;
    assign conflict_cnt = conf_cnt_q;
`endif

endmodule

// File: tb/tb_fiber_mem_arbiter.sv
// Self-checking bench for fiber_mem_arbiter: behavioural SRAM, reference memory and a response scoreboard.
module tb_fiber_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic        flush;
    logic        wr_valid;
    logic        wr_ready;
    logic [8:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [8:0]  rd_addr;
    logic [63:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [8:0]  addr_to_mem;
    logic [63:0] data_to_mem;
    logic        wen_to_mem;
    logic        ren_to_mem;
    logic [63:0] data_from_mem;
`ifdef FIBER_ARB_STATS_EN
    logic [15:0] wr_grant_cnt;
    logic [15:0] rd_grant_cnt;
    logic [15:0] conflict_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sram    [512];
    logic [63:0] ref_mem [512];
    logic [63:0] exp_q   [$];
    logic        expect_rsp = 1'b0;

    always #5 clk = ~clk;

    fiber_mem_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_en        (clk_en),
        .flush         (flush),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rsp_data      (rsp_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .addr_to_mem   (addr_to_mem),
        .data_to_mem   (data_to_mem),
        .wen_to_mem    (wen_to_mem),
        .ren_to_mem    (ren_to_mem),
        .data_from_mem (data_from_mem)
`ifdef FIBER_ARB_STATS_EN
        ,
        .wr_grant_cnt  (wr_grant_cnt),
        .rd_grant_cnt  (rd_grant_cnt),
        .conflict_cnt  (conflict_cnt)
`endif
    );

    // Behavioural single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (wen_to_mem) sram[addr_to_mem] <= data_to_mem;
        if (ren_to_mem) data_from_mem <= sram[addr_to_mem];
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [8:0] wa, input logic [63:0] wd,
                                 input logic rv, input logic [8:0] ra, input logic rr);
        @(posedge clk);
        #1;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        rd_valid  = rv;
        rd_addr   = ra;
        rsp_ready = rr;
    endtask

    // Scoreboard: expected read data is queued at grant and compared when consumed.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("mem_excl", 64'(wen_to_mem & ren_to_mem), 64'd0);
            if (expect_rsp) checkOutput("rsp_latency", 64'(rsp_valid), 64'd1);
            if (clk_en || flush) expect_rsp = rd_ready;
            if (rsp_valid && rsp_ready && clk_en && !flush) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    checkOutput("rsp_data", rsp_data, exp_q.pop_front());
                end
            end
            if (wr_ready) ref_mem[wr_addr] = wr_data;
            if (rd_ready) exp_q.push_back(ref_mem[rd_addr]);
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            sram[i]    = 64'd0;
            ref_mem[i] = 64'd0;
        end
        rst_n = 1'b1; clk_en = 1'b1; flush = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0; rsp_ready = 1'b1;

        #2 rst_n = 1'b0;
        #2;
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_wen", 64'(wen_to_mem), 64'd0);
        checkOutput("rst_ren", 64'(ren_to_mem), 64'd0);
        checkOutput("rst_wr_ready", 64'(wr_ready), 64'd0);
        checkOutput("rst_addr", 64'(addr_to_mem), 64'd0);
        checkOutput("rst_data", data_to_mem, 64'd0);
`ifdef FIBER_ARB_STATS_EN
        checkOutput("rst_stats", 64'({wr_grant_cnt, rd_grant_cnt, conflict_cnt}), 64'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] write-only burst");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 9'(i), 64'h10 + 64'(i), 1'b0, 9'd0, 1'b1);
            @(negedge clk);
            checkOutput("burst_wr_ready", 64'(wr_ready), 64'd1);
            checkOutput("burst_wen", 64'(wen_to_mem), 64'd1);
            checkOutput("burst_addr", 64'(addr_to_mem), 64'(i));
            checkOutput("burst_data", data_to_mem, 64'h10 + 64'(i));
        end
        applyStimulus(1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 1'b1);
        @(negedge clk);
        checkOutput("idle_wen", 64'(wen_to_mem), 64'd0);
        checkOutput("idle_addr_hold", 64'(addr_to_mem), 64'd7);
        checkOutput("idle_data_hold", data_to_mem, 64'h17);

        $display("[TB] conflict alternation");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 9'(8 + i), 64'h100 + 64'(i), 1'b1, 9'(i), 1'b1);
            @(negedge clk);
            checkOutput("alt_rd_ready", 64'(rd_ready), 64'((i % 2) == 0));
            checkOutput("alt_wr_ready", 64'(wr_ready), 64'((i % 2) == 1));
        end
        repeat (2) applyStimulus(1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 1'b1);

        $display("[TB] back-pressure");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 9'd0, 64'd0, 1'b1, 9'd3, 1'b0);
            @(negedge clk);
            checkOutput("bp_rd_ready", 64'(rd_ready), 64'(i < 2));
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 9'd0, 64'd0, 1'b0, 9'd3, 1'b1);
            @(negedge clk);
            checkOutput("bp_drain_valid", 64'(rsp_valid), 64'd1);
        end
        applyStimulus(1'b0, 9'd0, 64'd0, 1'b1, 9'd3, 1'b1);
        @(negedge clk);
        checkOutput("bp_empty", 64'(rsp_valid), 64'd0);
        checkOutput("bp_resume", 64'(rd_ready), 64'd1);
        applyStimulus(1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 1'b1);

        $display("[TB] read-after-write");
        applyStimulus(1'b1, 9'd5, 64'hDEAD_BEEF, 1'b0, 9'd0, 1'b1);
        @(negedge clk);
        checkOutput("raw_wr_ready", 64'(wr_ready), 64'd1);
        applyStimulus(1'b0, 9'd0, 64'd0, 1'b1, 9'd5, 1'b1);
        @(negedge clk);
        checkOutput("raw_rd_ready", 64'(rd_ready), 64'd1);
        applyStimulus(1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 1'b1);
        @(negedge clk);
        checkOutput("raw_valid", 64'(rsp_valid), 64'd1);
        checkOutput("raw_data", rsp_data, 64'hDEAD_BEEF);

        $display("[TB] clock enable and flush");
        applyStimulus(1'b0, 9'd0, 64'd0, 1'b1, 9'd0, 1'b0);
        applyStimulus(1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 1'b0);
        @(negedge clk);
        checkOutput("ce_pre_valid", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 9'd20, 64'h55, 1'b1, 9'd1, 1'b1);
            clk_en = 1'b0;
            @(negedge clk);
            checkOutput("ce_wr_ready", 64'(wr_ready), 64'd0);
            checkOutput("ce_rd_ready", 64'(rd_ready), 64'd0);
            checkOutput("ce_mem_en", 64'(wen_to_mem | ren_to_mem), 64'd0);
            checkOutput("ce_rsp_hold", 64'(rsp_valid), 64'd1);
        end
        applyStimulus(1'b0, 9'd0, 64'd0, 1'b1, 9'd1, 1'b0);
        clk_en = 1'b1;
        @(negedge clk);
        checkOutput("ce_resume_rd", 64'(rd_ready), 64'd1);
        applyStimulus(1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 1'b0);
        applyStimulus(1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 1'b0);
        flush = 1'b1;
        exp_q.delete();
        expect_rsp = 1'b0;
        @(negedge clk);
        checkOutput("flush_pre_valid", 64'(rsp_valid), 64'd1);
        applyStimulus(1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 1'b1);
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_rsp_valid", 64'(rsp_valid), 64'd0);
`ifdef FIBER_ARB_STATS_EN
        checkOutput("flush_stats", 64'({wr_grant_cnt, rd_grant_cnt, conflict_cnt}), 64'd0);
`endif
        applyStimulus(1'b1, 9'd30, 64'h66, 1'b1, 9'd2, 1'b1);
        @(negedge clk);
        checkOutput("flush_first_rd", 64'(rd_ready), 64'd1);
        checkOutput("flush_first_wr", 64'(wr_ready), 64'd0);
        repeat (2) applyStimulus(1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 1'b1);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 9'd0, 64'd0, 1'b1, 9'd4, 1'b1);
        @(negedge clk);
        checkOutput("mid_rd_grant", 64'(rd_ready), 64'd1);
        applyStimulus(1'b1, 9'd6, 64'h77, 1'b1, 9'd4, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        expect_rsp = 1'b0;
        #1;
        checkOutput("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("mid_mem_en", 64'(wen_to_mem | ren_to_mem), 64'd0);
        checkOutput("mid_ready", 64'(wr_ready | rd_ready), 64'd0);
        applyStimulus(1'b1, 9'd6, 64'h77, 1'b1, 9'd4, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("mid_first_rd", 64'(rd_ready), 64'd1);
        checkOutput("mid_first_wr", 64'(wr_ready), 64'd0);
        repeat (3) applyStimulus(1'b0, 9'd0, 64'd0, 1'b0, 9'd0, 1'b1);
        @(negedge clk);

        checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
